// File: rtl/io_uart_if.sv
// CPU I/O bus bundle between the SYS strobe generator and the UART peripheral.
interface io_uart_if;
    logic        io_read_enable;
    logic        io_write_enable;
    logic [15:0] io_address;
    logic [15:0] io_write_data;
    logic [15:0] io_read_data;

    modport master (
        output io_read_enable,
        output io_write_enable,
        output io_address,
        output io_write_data,
        input  io_read_data
    );

    modport slave (
        input  io_read_enable,
        input  io_write_enable,
        input  io_address,
        input  io_write_data,
        output io_read_data
    );
endinterface

// File: rtl/io_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, deserializer + RX FIFO,
// three-word register window (DATA, STAT, CLEAR) with a registered read port.
module io_uart #(
    parameter logic [15:0] BASE_ADDR    = 16'h0000,
    parameter logic [15:0] CLKS_PER_BIT = 16'd104,
    parameter int          TX_DEPTH     = 8,
    parameter int          RX_DEPTH     = 8
) (
    input  logic       clk,
    input  logic       reset,
    io_uart_if.slave   bus,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int          TX_AW     = $clog2(TX_DEPTH);
    localparam int          RX_AW     = $clog2(RX_DEPTH);
    localparam logic [15:0] BIT_LAST  = CLKS_PER_BIT - 16'd1;
    localparam logic [15:0] HALF_LAST = (CLKS_PER_BIT >> 1) - 16'd1;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_HOLD} rx_state_t;

    // ---------------- register window decode ----------------
    logic sel_data, sel_stat, sel_clear;
    logic wr_data, rd_data, wr_clear;
    logic [2:0] clr_mask;

    assign sel_data  = (bus.io_address == BASE_ADDR);
    assign sel_stat  = (bus.io_address == BASE_ADDR + 16'd4);
    assign sel_clear = (bus.io_address == BASE_ADDR + 16'd8);
    assign wr_data   = bus.io_write_enable & sel_data;
    assign rd_data   = bus.io_read_enable & sel_data;
    assign wr_clear  = bus.io_write_enable & sel_clear;
    assign clr_mask  = wr_clear ? bus.io_write_data[2:0] : 3'b000;

    // Upper write-data byte has no function in this peripheral.
    logic unused_wdata;
    assign unused_wdata = ^bus.io_write_data[15:8];

    // ---------------- TX FIFO ----------------
    logic [7:0]     tx_mem [TX_DEPTH];
    logic [TX_AW:0] tx_wr_ptr, tx_rd_ptr;
    logic           tx_fifo_empty, tx_fifo_full, tx_push, tx_pop;
    logic [7:0]     tx_head;

    assign tx_fifo_empty = (tx_wr_ptr == tx_rd_ptr);
    assign tx_fifo_full  = ((tx_wr_ptr ^ tx_rd_ptr) == {1'b1, {TX_AW{1'b0}}});
    assign tx_push       = wr_data & ~tx_fifo_full;
    assign tx_head       = tx_mem[tx_rd_ptr[TX_AW-1:0]];

    // TX FIFO pointers advance on accepted push and serializer pop.
    always_ff @(posedge clk) begin
        // NOTE: sequential state always uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            tx_wr_ptr <= '0;
            tx_rd_ptr <= '0;
        end else begin
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + 1'b1;
        end
    end

    // TX FIFO storage write.
    always_ff @(posedge clk) begin
        // NOTE: storage is deliberately not reset; the pointers define which
        // entries are valid, and a reset-free array maps onto plain RAM.
        if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= bus.io_write_data[7:0];
    end

    // ---------------- TX serializer ----------------
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_timer, tx_timer_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_shift, tx_shift_n;
    logic        tx_bit_done, tx_empty;

    assign tx_bit_done = (tx_timer == BIT_LAST);
    assign tx_empty    = tx_fifo_empty & (tx_state == TX_IDLE);

    // TX state register and serial output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_timer <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            uart_tx  <= 1'b1;
        end else begin
            tx_state <= tx_state_n;
            tx_timer <= tx_timer_n;
            tx_bit   <= tx_bit_n;
            tx_shift <= tx_shift_n;
            uart_tx  <= (tx_state == TX_START) ? 1'b0 :
                        (tx_state == TX_DATA)  ? tx_shift[0] : 1'b1;
        end
    end

    // TX next-state: STOP chains straight into the next START when bytes wait.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        tx_state_n = tx_state;
        tx_timer_n = tx_timer + 16'd1;
        tx_bit_n   = tx_bit;
        tx_shift_n = tx_shift;
        tx_pop     = 1'b0;
        unique case (tx_state)
            TX_IDLE: begin
                tx_timer_n = '0;
                if (!tx_fifo_empty) begin
                    tx_pop     = 1'b1;
                    tx_shift_n = tx_head;
                    tx_state_n = TX_START;
                end
            end
            TX_START: begin
                if (tx_bit_done) begin
                    tx_timer_n = '0;
                    tx_bit_n   = '0;
                    tx_state_n = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_bit_done) begin
                    tx_timer_n = '0;
                    tx_shift_n = {1'b0, tx_shift[7:1]};
                    tx_bit_n   = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) tx_state_n = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_bit_done) begin
                    tx_timer_n = '0;
                    if (!tx_fifo_empty) begin
                        tx_pop     = 1'b1;
                        tx_shift_n = tx_head;
                        tx_state_n = TX_START;
                    end else begin
                        tx_state_n = TX_IDLE;
                    end
                end
            end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    // ---------------- RX deserializer ----------------
    logic        rx_sync1, rx_sync2, rx_prev;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_timer, rx_timer_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic [7:0]  rx_shift, rx_shift_n;
    logic        rx_byte_valid, rx_frame_bad;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_sync1 <= 1'b1;
            rx_sync2 <= 1'b1;
            rx_prev  <= 1'b1;
        end else begin
            rx_sync1 <= uart_rx;
            rx_sync2 <= rx_sync1;
            rx_prev  <= rx_sync2;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rx_timer <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_timer <= rx_timer_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // RX next-state: half-bit start check, then one sample per bit period.
    always_comb begin
        rx_state_n    = rx_state;
        rx_timer_n    = rx_timer + 16'd1;
        rx_bit_n      = rx_bit;
        rx_shift_n    = rx_shift;
        rx_byte_valid = 1'b0;
        rx_frame_bad  = 1'b0;
        unique case (rx_state)
            RX_IDLE: begin
                rx_timer_n = '0;
                if (rx_prev && !rx_sync2) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_timer == HALF_LAST) begin
                    rx_timer_n = '0;
                    rx_bit_n   = '0;
                    // A line already high again was only a glitch.
                    rx_state_n = rx_sync2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_timer == BIT_LAST) begin
                    rx_timer_n = '0;
                    rx_shift_n = {rx_sync2, rx_shift[7:1]};
                    rx_bit_n   = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_timer == BIT_LAST) begin
                    rx_timer_n = '0;
                    if (rx_sync2) begin
                        rx_byte_valid = 1'b1;
                        rx_state_n    = RX_IDLE;
                    end else begin
                        rx_frame_bad = 1'b1;
                        rx_state_n   = RX_HOLD;
                    end
                end
            end
            RX_HOLD: begin
                // Wait out a break/bad frame before looking for a new start.
                rx_timer_n = '0;
                if (rx_sync2) rx_state_n = RX_IDLE;
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]     rx_mem [RX_DEPTH];
    logic [RX_AW:0] rx_wr_ptr, rx_rd_ptr;
    logic           rx_fifo_empty, rx_fifo_full, rx_push, rx_pop;
    logic [7:0]     rx_head;

    assign rx_fifo_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_fifo_full  = ((rx_wr_ptr ^ rx_rd_ptr) == {1'b1, {RX_AW{1'b0}}});
    assign rx_push       = rx_byte_valid & ~rx_fifo_full;
    assign rx_pop        = rd_data & ~rx_fifo_empty;
    assign rx_head       = rx_mem[rx_rd_ptr[RX_AW-1:0]];

    // RX FIFO pointers advance on received byte and CPU DATA read.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_wr_ptr <= '0;
            rx_rd_ptr <= '0;
        end else begin
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + 1'b1;
        end
    end

    // RX FIFO storage write.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= rx_shift;
    end

    // ---------------- sticky status and read port ----------------
    logic        frame_err, rx_overrun, tx_overflow;
    logic [15:0] rd_next, rd_q;

    // Sticky bits: a set event in the same cycle as its CLEAR write wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_err   <= 1'b0;
            rx_overrun  <= 1'b0;
            tx_overflow <= 1'b0;
        end else begin
            frame_err   <= (frame_err   & ~clr_mask[2]) | rx_frame_bad;
            rx_overrun  <= (rx_overrun  & ~clr_mask[1]) | (rx_byte_valid & rx_fifo_full);
            tx_overflow <= (tx_overflow & ~clr_mask[0]) | (wr_data & tx_fifo_full);
        end
    end

    // Read mux from pre-edge state; CLEAR and unmapped addresses read as 0.
    always_comb begin
        rd_next = '0;
        if (sel_data) begin
            rd_next = rx_fifo_empty ? 16'h0000 : {7'b0, 1'b1, rx_head};
        end else if (sel_stat) begin
            rd_next = {11'b0, frame_err, rx_overrun, tx_overflow, ~rx_fifo_empty, tx_empty};
        end
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk) begin
        if (reset)                   rd_q <= '0;
        else if (bus.io_read_enable) rd_q <= rd_next;
    end

    assign bus.io_read_data = rd_q;

endmodule

// File: tb/tb_io_uart.sv
// Self-checking bench for io_uart: TX frames checked cycle-by-cycle against a
// waveform model, RX bytes checked through a scoreboard queue.
module tb_io_uart;

    localparam logic [15:0] BASE = 16'h0040;
    localparam int          CPB  = 4;
    localparam int          TXD  = 8;
    localparam int          RXD  = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic uart_tx;

    io_uart_if bus ();

    io_uart #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (16'(CPB)),
        .TX_DEPTH     (TXD),
        .RX_DEPTH     (RXD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    logic m_ferr = 1'b0, m_ovr = 1'b0, m_txo = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Expected line level for each of the 10*CPB cycles of a frame.
    function automatic logic [10*CPB-1:0] frame_wave(input logic [7:0] b);
        logic [9:0]          f;
        logic [10*CPB-1:0]   w;
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 10*CPB; i++) w[i] = f[i/CPB];
        return w;
    endfunction

    // TX monitor: capture each frame from its first low cycle, compare to model.
    initial begin : tx_monitor
        logic [10*CPB-1:0] w;
        logic [7:0]        e;
        bit                aborted;
        forever begin
            @(negedge clk);
            if (!reset && uart_tx === 1'b0) begin
                w       = '0;
                aborted = 1'b0;
                for (int c = 1; c < 10*CPB; c++) begin
                    @(negedge clk);
                    if (reset) begin
                        aborted = 1'b1;
                        break;
                    end
                    w[c] = uart_tx;
                end
                if (aborted) begin
                    exp_tx.delete();
                end else if (exp_tx.size() == 0) begin
                    chk("tx_unexpected_frame", 64'(w), 64'(0));
                end else begin
                    e = exp_tx.pop_front();
                    chk($sformatf("tx_frame_%02h", e), 64'(w), 64'(frame_wave(e)));
                end
            end
        end
    end

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        bus.io_write_enable = 1'b1;
        bus.io_address      = a;
        bus.io_write_data   = d;
        @(negedge clk);
        bus.io_write_enable = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        @(negedge clk);
        bus.io_read_enable = 1'b1;
        bus.io_address     = a;
        @(negedge clk);
        bus.io_read_enable = 1'b0;
        d = bus.io_read_data;
    endtask

    task automatic check_stat(input string tag);
        logic [15:0] d;
        bus_read(BASE + 16'd4, d);
        chk(tag, 64'(d), 64'({11'b0, m_ferr, m_ovr, m_txo, exp_rx.size() != 0, 1'b1}));
    endtask

    task automatic read_rx(input string tag);
        logic [15:0] d;
        logic [15:0] e;
        bus_read(BASE, d);
        e = (exp_rx.size() != 0) ? {7'b0, 1'b1, exp_rx.pop_front()} : 16'h0000;
        chk(tag, 64'(d), 64'(e));
    endtask

    // Drive one frame on uart_rx and update the RX model.
    task automatic send_rx(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rx = f[i];
            repeat (CPB - 1) @(negedge clk);
        end
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (2*CPB) @(negedge clk);
        if (!stop)                   m_ferr = 1'b1;
        else if (exp_rx.size() < RXD) exp_rx.push_back(b);
        else                          m_ovr = 1'b1;
    endtask

    task automatic wait_tx_drain(input string tag);
        for (int i = 0; i < 4000 && exp_tx.size() != 0; i++) @(negedge clk);
        chk(tag, 64'(exp_tx.size()), 64'(0));
        repeat (8) @(negedge clk);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : stimulus
        logic [15:0] d;
        bus.io_read_enable  = 1'b0;
        bus.io_write_enable = 1'b0;
        bus.io_address      = '0;
        bus.io_write_data   = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("reset_uart_tx", 64'(uart_tx), 64'(1));
        chk("reset_read_data", 64'(bus.io_read_data), 64'(0));
        reset = 1'b0;
        check_stat("stat_after_reset");

        // Single byte 0xA5; line busy right after the write.
        exp_tx.push_back(8'hA5);
        bus_write(BASE, 16'h00A5);
        bus_read(BASE + 16'd4, d);
        chk("stat_tx_busy", 64'(d), 64'(16'h0000));
        wait_tx_drain("drain_a5");
        check_stat("stat_tx_idle");

        // Back-to-back burst of TXD+2 bytes: first pops at once, last one dropped.
        @(negedge clk);
        bus.io_write_enable = 1'b1;
        bus.io_address      = BASE;
        for (int i = 0; i < TXD + 2; i++) begin
            bus.io_write_data = 16'(8'h10 + i);
            if (i < TXD + 1) exp_tx.push_back(8'(8'h10 + i));
            @(negedge clk);
        end
        bus.io_write_enable = 1'b0;
        m_txo = 1'b1;
        bus_read(BASE + 16'd4, d);
        chk("stat_overflow_busy", 64'(d), 64'(16'h0004));
        wait_tx_drain("drain_burst");
        check_stat("stat_overflow_idle");
        bus_write(BASE + 16'd8, 16'h0001);
        m_txo = 1'b0;
        check_stat("stat_overflow_cleared");

        // Single RX byte, then empty read.
        send_rx(8'h3C, 1'b1);
        read_rx("rx_3c");
        read_rx("rx_empty");

        // RXD+1 frames without reading: overrun, first RXD bytes kept in order.
        for (int i = 0; i < RXD + 1; i++) send_rx(8'(8'hC1 + 7*i), 1'b1);
        check_stat("stat_overrun");
        for (int i = 0; i < RXD + 1; i++) read_rx($sformatf("rx_fifo_%0d", i));
        bus_write(BASE + 16'd8, 16'h0002);
        m_ovr = 1'b0;
        check_stat("stat_overrun_cleared");

        // Bad stop bit: frame_err, nothing pushed.
        send_rx(8'h55, 1'b0);
        check_stat("stat_frame_err");
        read_rx("rx_after_frame_err");

        // One-cycle glitch on the idle line.
        @(negedge clk);
        uart_rx = 1'b0;
        @(negedge clk);
        uart_rx = 1'b1;
        repeat (20*CPB) @(negedge clk);
        read_rx("rx_after_glitch");
        send_rx(8'h81, 1'b1);
        read_rx("rx_after_recovery");
        bus_write(BASE + 16'd8, 16'h0004);
        m_ferr = 1'b0;
        check_stat("stat_frame_err_cleared");

        // Unmapped and write-only addresses.
        bus_write(BASE + 16'd12, 16'h0077);
        bus_write(BASE + 16'd4,  16'h0066);
        bus_read(BASE + 16'd12, d);
        chk("read_unmapped", 64'(d), 64'(0));
        bus_read(BASE + 16'd8, d);
        chk("read_clear_reg", 64'(d), 64'(0));
        repeat (12*CPB) @(negedge clk);

        // Reset in the middle of a TX frame with an RX byte pending.
        send_rx(8'h5A, 1'b1);
        check_stat("stat_rx_pending");
        exp_tx.push_back(8'h00);
        exp_tx.push_back(8'h22);
        exp_tx.push_back(8'h33);
        bus_write(BASE, 16'h0000);
        bus_write(BASE, 16'h0022);
        bus_write(BASE, 16'h0033);
        repeat (3*CPB) @(negedge clk);
        chk("tx_low_before_reset", 64'(uart_tx), 64'(0));
        reset = 1'b1;
        @(negedge clk);
        chk("mid_frame_reset_tx", 64'(uart_tx), 64'(1));
        chk("mid_frame_reset_rdata", 64'(bus.io_read_data), 64'(0));
        reset = 1'b0;
        exp_tx.delete();
        exp_rx.delete();
        check_stat("stat_after_mid_reset");
        repeat (30*CPB) @(negedge clk);
        read_rx("rx_after_mid_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
